// File: rtl/decode_fwd_regfile_p.sv
// Y86-64 PIPE decode stage: two-write-port register file, operand forwarding,
// load/use detection and the D->E pipeline register with bubble insertion.
module decode_fwd_regfile_p #(
    parameter int XLEN    = 64,
    parameter int NREGS   = 16,
    parameter int RW      = 4,
    parameter int SP_ID   = 4,
    parameter logic [XLEN-1:0] SP_INIT = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      D_stat,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      D_ifun,
    input  logic [RW-1:0]   D_rA,
    input  logic [RW-1:0]   D_rB,
    input  logic [XLEN-1:0] D_valC,
    input  logic [XLEN-1:0] D_valP,
    input  logic [RW-1:0]   e_dstE,
    input  logic [XLEN-1:0] e_valE,
    input  logic [RW-1:0]   M_dstE,
    input  logic [RW-1:0]   M_dstM,
    input  logic [XLEN-1:0] M_valE,
    input  logic [XLEN-1:0] m_valM,
    input  logic [RW-1:0]   W_dstE,
    input  logic [RW-1:0]   W_dstM,
    input  logic [XLEN-1:0] W_valE,
    input  logic [XLEN-1:0] W_valM,
    input  logic            E_bubble,
    output logic            load_use,
    output logic [3:0]      E_stat,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [XLEN-1:0] E_valC,
    output logic [XLEN-1:0] E_valA,
    output logic [XLEN-1:0] E_valB,
    output logic [RW-1:0]   E_dstE,
    output logic [RW-1:0]   E_dstM,
    output logic [RW-1:0]   E_srcA,
    output logic [RW-1:0]   E_srcB,
    input  logic [RW-1:0]   dbg_sel,
    output logic [XLEN-1:0] dbg_val
);
    localparam logic [RW-1:0] RNONE = RW'(NREGS - 1);
    localparam logic [RW-1:0] SP    = RW'(SP_ID);

    typedef struct packed {
        logic [3:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [XLEN-1:0] valC;
        logic [XLEN-1:0] valA;
        logic [XLEN-1:0] valB;
        logic [RW-1:0]   dstE;
        logic [RW-1:0]   dstM;
        logic [RW-1:0]   srcA;
        logic [RW-1:0]   srcB;
    } ereg_t;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [RW-1:0]   srcA, srcB, dstE, dstM;
    logic [XLEN-1:0] valA, valB;
    ereg_t           bub, e_d, e_q;

    // The RNONE entry is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= (i == SP_ID) ? SP_INIT : '0;
        end else begin
            if (W_dstE != RNONE) regs_q[W_dstE] <= W_valE;
            if (W_dstM != RNONE) regs_q[W_dstM] <= W_valM;
        end
    end

    assign dbg_val = (dbg_sel == RNONE) ? '0 : regs_q[dbg_sel];

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (D_icode)
            4'h2: begin srcA = D_rA; dstE = D_rB; end
            4'h3: dstE = D_rB;
            4'h4: begin srcA = D_rA; srcB = D_rB; end
            4'h5: begin srcB = D_rB; dstM = D_rA; end
            4'h6: begin srcA = D_rA; srcB = D_rB; dstE = D_rB; end
            4'h8: begin srcB = SP; dstE = SP; end
            4'h9: begin srcA = SP; srcB = SP; dstE = SP; end
            4'hA: begin srcA = D_rA; srcB = SP; dstE = SP; end
            // popq reads %rsp for the address; rA is only its load destination
            4'hB: begin srcA = SP; srcB = SP; dstE = SP; dstM = D_rA; end
            default: ;
        endcase
    end

    // Youngest producer wins: execute, then memory (load data before ALU), then writeback.
    always_comb begin
        if (D_icode == 4'h7 || D_icode == 4'h8) valA = D_valP;
        else if (srcA == RNONE)                 valA = '0;
        else if (srcA == e_dstE)                valA = e_valE;
        else if (srcA == M_dstM)                valA = m_valM;
        else if (srcA == M_dstE)                valA = M_valE;
        else if (srcA == W_dstM)                valA = W_valM;
        else if (srcA == W_dstE)                valA = W_valE;
        else                                    valA = regs_q[srcA];
    end

    always_comb begin
        if (srcB == RNONE)       valB = '0;
        else if (srcB == e_dstE) valB = e_valE;
        else if (srcB == M_dstM) valB = m_valM;
        else if (srcB == M_dstE) valB = M_valE;
        else if (srcB == W_dstM) valB = W_valM;
        else if (srcB == W_dstE) valB = W_valE;
        else                     valB = regs_q[srcB];
    end

    assign load_use = (e_q.icode == 4'h5 || e_q.icode == 4'hB) && (e_q.dstM != RNONE) &&
                      (e_q.dstM == srcA || e_q.dstM == srcB);

    always_comb begin
        bub       = '0;
        bub.stat  = 4'h1;
        bub.icode = 4'h1;
        bub.dstE  = RNONE;
        bub.dstM  = RNONE;
        bub.srcA  = RNONE;
        bub.srcB  = RNONE;
        e_d = '{stat: D_stat, icode: D_icode, ifun: D_ifun, valC: D_valC, valA: valA,
                valB: valB, dstE: dstE, dstM: dstM, srcA: srcA, srcB: srcB};
        if (load_use || E_bubble) e_d = bub;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) e_q <= bub;
        else        e_q <= e_d;
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.valC;
    assign E_valA  = e_q.valA;
    assign E_valB  = e_q.valB;
    assign E_dstE  = e_q.dstE;
    assign E_dstM  = e_q.dstM;
    assign E_srcA  = e_q.srcA;
    assign E_srcB  = e_q.srcB;
endmodule
